fifo_rd_stream: RTL

Read-side adapter for the team's synchronous FIFO. It pops words from the FIFO's read port, where data arrives one cycle after the read enable. It presents those words to a downstream consumer as a valid/ready stream. A 2-entry skid buffer absorbs the read latency, so the block sustains one word per clock under continuous ready and loses nothing under backpressure.

---
 rtl/fifo_rd_stream.sv | 82 ++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: pops a synchronous FIFO (one-cycle read latency) into a valid/ready stream
// through a 2-entry skid buffer. Define FIFO_RD_STATS_EN to add the pop_count_o counter.
`timescale 1ns/1ps
module fifo_rd_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             fifo_empty_i,
  output logic             fifo_rd_en_o,
  input  logic [WIDTH-1:0] fifo_data_i,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  input  logic             m_ready_i,
  output logic [1:0]       occupancy_o
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [15:0]      pop_count_o
`endif
);

  logic [1:0]       occ;
  logic             inflight_p1;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [WIDTH-1:0] head_next;
  logic [WIDTH-1:0] tail_next;
  logic             pop;
  logic [2:0]       credit;

  assign pop         = m_valid_o && m_ready_i;
  assign m_valid_o   = (occ != 2'd0);
  assign m_data_o    = head;
  assign occupancy_o = occ;

  // Words owned after this cycle; a new read is only issued if a slot is guaranteed for it.
  assign credit       = {1'b0, occ} + {2'b00, inflight_p1} - {2'b00, pop};
  assign fifo_rd_en_o = !reset_i && !fifo_empty_i && (credit < 3'd2);

  always_comb begin
    head_next = pop ? tail : head;
    tail_next = pop ? '0 : tail;
    if (inflight_p1) begin
      // The arriving word lands in the first slot left free after any pop shift.
      if ((occ == 2'd0) || ((occ == 2'd1) && pop)) begin
        head_next = fifo_data_i;
      end else begin
        tail_next = fifo_data_i;
      end
    end
  end

  // Stage p1: read-enable pipeline and skid buffer state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      occ         <= 2'd0;
      inflight_p1 <= 1'b0;
      head        <= '0;
      tail        <= '0;
    end else begin
      occ         <= credit[1:0];
      inflight_p1 <= fifo_rd_en_o;
      head        <= head_next;
      tail        <= tail_next;
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [15:0] pop_count;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pop_count <= 16'd0;
    end else if (pop) begin
      pop_count <= pop_count + 16'd1;
    end
  end

  assign pop_count_o = pop_count;
`endif

endmodule
